buzzer_driver: RTL and testbench



---
 rtl/buzzer_pkg.sv | 25 ++
 rtl/buzzer_if.sv | 36 +++
 rtl/buzzer_driver_tone_divider.sv | 59 +++++
 rtl/buzzer_driver.sv | 152 +++++++++++++++
 tb/tb_buzzer_driver.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/buzzer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : buzzer_pkg
// Description : Shared types and helpers for the buzzer driver block.
//               - buzz_state_t : top-level beep sequencer states
//               - cnt_width()  : width of a counter that must hold 0..n-1,
//                                never narrower than one bit
// Revision    : 1.0 - initial release
// ============================================================================
package buzzer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEEP = 2'd1,
        GAP  = 2'd2
    } buzz_state_t;

    // A terminal count of 0 (n == 1) still needs a one-bit register,
    // hence the floor of 2 before taking the log.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : buzzer_pkg
`default_nettype wire

// File: rtl/buzzer_if.sv
`default_nettype none
// ============================================================================
// Module      : buzzer_if
// Description : Request/status bundle between event sources and the buzzer
//               driver.
//               pulse : beep request, one beep per cycle sampled high
//               buzz  : tone level for the buzzer pin
//               busy  : a beep or its trailing gap is in progress
//               drop  : a request was lost because the queue was full
//               master : event-source side (drives pulse)
//               slave  : buzzer_driver side (drives buzz/busy/drop)
// Revision    : 1.0 - initial release
// ============================================================================
interface buzzer_if;

    logic pulse;
    logic buzz;
    logic busy;
    logic drop;

    modport master (
        output pulse,
        input  buzz,
        input  busy,
        input  drop
    );

    modport slave (
        input  pulse,
        output buzz,
        output busy,
        output drop
    );

endinterface : buzzer_if
`default_nettype wire

// File: rtl/buzzer_driver_tone_divider.sv
`default_nettype none
// ============================================================================
// Module      : tone_divider
// Description : Square-wave generator for the beep tone. While enable is
//               high the registered level toggles every TONE_HALF cycles.
//               The cycle after enable rises the level is 1 with the phase
//               counter cleared, so every beep starts with the same phase.
//               With enable low the level is held at 0.
//               clock  : system clock
//               reset  : synchronous, active-high
//               enable : tone requested for the next cycle
//               level  : registered tone output
// Revision    : 1.0 - initial release
// ============================================================================
module tone_divider
    import buzzer_pkg::*;
#(
    parameter int TONE_HALF = 2
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic enable,
    output logic      level
);

    localparam int             c_W    = cnt_width(TONE_HALF);
    localparam logic [c_W-1:0] c_LAST = c_W'(TONE_HALF - 1);

    logic [c_W-1:0] r_cnt;
    logic           r_en_d;
    logic           r_level;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt   <= '0;
            r_en_d  <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_en_d <= enable;
            if (!enable) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else if (!r_en_d) begin
                // Rising edge of enable: start a fresh tone, high phase first.
                r_cnt   <= '0;
                r_level <= 1'b1;
            end else if (r_cnt == c_LAST) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;

endmodule : tone_divider
`default_nettype wire

// File: rtl/buzzer_driver.sv
`default_nettype none
// ============================================================================
// Module      : buzzer_driver
// Description : Turns single-cycle event pulses into beeps: BEEP_LEN cycles
//               of square-wave tone followed by GAP_LEN silent cycles.
//               Requests arriving during a beep or gap are counted in a
//               saturating pending counter and each one is played as its own
//               beep. Requests beyond saturation raise drop for one cycle.
//               clock : system clock
//               reset : synchronous, active-high
//               bus   : buzzer_if.slave (pulse in; buzz, busy, drop out)
// Revision    : 1.0 - initial release
// ============================================================================
module buzzer_driver
    import buzzer_pkg::*;
#(
    parameter int TONE_HALF = 2,
    parameter int BEEP_LEN  = 8,
    parameter int GAP_LEN   = 4,
    parameter int PEND_W    = 2
) (
    input  wire logic clock,
    input  wire logic reset,
    buzzer_if.slave   bus
);

    localparam int                c_BW        = cnt_width(BEEP_LEN);
    localparam int                c_GW        = cnt_width(GAP_LEN);
    localparam logic [c_BW-1:0]   c_BEEP_LAST = c_BW'(BEEP_LEN - 1);
    localparam logic [c_GW-1:0]   c_GAP_LAST  = c_GW'(GAP_LEN - 1);
    localparam logic [PEND_W-1:0] c_PEND_MAX  = {PEND_W{1'b1}};

    buzz_state_t       r_state;
    buzz_state_t       w_state_nxt;
    logic [c_BW-1:0]   r_beep_cnt;
    logic [c_BW-1:0]   w_beep_cnt_nxt;
    logic [c_GW-1:0]   r_gap_cnt;
    logic [c_GW-1:0]   w_gap_cnt_nxt;
    logic [PEND_W-1:0] r_pending;
    logic [PEND_W-1:0] w_pending_nxt;
    logic              w_queue;
    logic              w_consume;
    logic              w_drop_nxt;
    logic              r_busy;
    logic              r_drop;
    logic              w_tone;

    // ------------------------------------------------------------------------
    // State, counters and pending queue: registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_beep_cnt <= '0;
            r_gap_cnt  <= '0;
            r_pending  <= '0;
            r_busy     <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beep_cnt <= w_beep_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_pending  <= w_pending_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_drop     <= w_drop_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, counters and pending queue: combinational
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_beep_cnt_nxt = '0;
        w_gap_cnt_nxt  = '0;
        w_pending_nxt  = r_pending;
        w_queue        = 1'b0;
        w_consume      = 1'b0;
        w_drop_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                // An idle request starts immediately and is never queued.
                if (bus.pulse) begin
                    w_state_nxt = BEEP;
                end
            end

            BEEP: begin
                w_queue = bus.pulse;
                if (r_beep_cnt == c_BEEP_LAST) begin
                    w_state_nxt = GAP;
                end else begin
                    w_beep_cnt_nxt = r_beep_cnt + 1'b1;
                end
            end

            GAP: begin
                w_queue = bus.pulse;
                if (r_gap_cnt == c_GAP_LAST) begin
                    // A request in this very cycle counts as pending, so it
                    // chains straight into the next beep.
                    if ((r_pending != '0) || bus.pulse) begin
                        w_state_nxt = BEEP;
                        w_consume   = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // A new request and a consume in the same cycle cancel out; this also
        // covers the saturated case, where the request is not lost because a
        // slot is freed in the same cycle.
        if (w_queue && !w_consume) begin
            if (r_pending == c_PEND_MAX) begin
                w_drop_nxt = 1'b1;
            end else begin
                w_pending_nxt = r_pending + 1'b1;
            end
        end else if (!w_queue && w_consume) begin
            // Consume without a new request implies r_pending is non-zero.
            w_pending_nxt = r_pending - 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Tone: enabled for every cycle the next state is BEEP, so the first
    // beep cycle already shows the high phase and leaving BEEP silences it.
    // ------------------------------------------------------------------------
    tone_divider #(
        .TONE_HALF (TONE_HALF)
    ) u_tone_divider (
        .clock  (clock),
        .reset  (reset),
        .enable (w_state_nxt == BEEP),
        .level  (w_tone)
    );

    assign bus.buzz = w_tone;
    assign bus.busy = r_busy;
    assign bus.drop = r_drop;

endmodule : buzzer_driver
`default_nettype wire

// File: tb/tb_buzzer_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_buzzer_driver
// Description : Self-checking bench for buzzer_driver. Each scenario is a
//               table of pulse cycles plus the expected beep start cycles,
//               the busy fall cycle, drop cycles and an optional reset
//               cycle; the expected {buzz,busy,drop} for each cycle is
//               derived from that table and queued, then compared against
//               the DUT one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buzzer_driver;

    localparam int c_TONE_HALF = 2;
    localparam int c_BEEP_LEN  = 8;
    localparam int c_GAP_LEN   = 4;
    localparam int c_PEND_W    = 2;

    typedef logic [2:0] vec_t;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    buzzer_if bus ();

    buzzer_driver #(
        .TONE_HALF (c_TONE_HALF),
        .BEEP_LEN  (c_BEEP_LEN),
        .GAP_LEN   (c_GAP_LEN),
        .PEND_W    (c_PEND_W)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int   n_vec = 0;
    int   n_err = 0;

    bit   pat [64];
    int   starts [$];
    int   drops [$];
    int   fall;
    int   rst_cyc;
    vec_t sb [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected outputs for cycle c (value visible after edge c-1).
    function automatic vec_t exp_vec(input int c);
        logic bz;
        logic bs;
        logic dr;
        bz = 1'b0;
        bs = 1'b0;
        dr = 1'b0;
        if (rst_cyc >= 0 && c > rst_cyc) begin
            return 3'b000;
        end
        foreach (starts[i]) begin
            if (c >= starts[i] && c < starts[i] + c_BEEP_LEN &&
                (((c - starts[i]) / c_TONE_HALF) % 2) == 0) begin
                bz = 1'b1;
            end
        end
        if (starts.size() > 0 && c >= starts[0] && c < fall) begin
            bs = 1'b1;
        end
        foreach (drops[i]) begin
            if (drops[i] == c) begin
                dr = 1'b1;
            end
        end
        return {bz, bs, dr};
    endfunction

    task automatic clear_scn();
        foreach (pat[i]) pat[i] = 1'b0;
        starts.delete();
        drops.delete();
        fall    = 0;
        rst_cyc = -1;
    endtask

    task automatic do_reset(input string name);
        reset     = 1'b1;
        bus.pulse = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_val($sformatf("%s reset buzz", name), bus.buzz, 0);
        check_val($sformatf("%s reset busy", name), bus.busy, 0);
        check_val($sformatf("%s reset drop", name), bus.drop, 0);
    endtask

    task automatic run_scn(input string name, input int n);
        vec_t e;
        do_reset(name);
        for (int k = 0; k < n; k++) begin
            bus.pulse = pat[k];
            reset     = (k == rst_cyc);
            sb.push_back(exp_vec(k + 1));
            @(posedge clock);
            #1;
            e = sb.pop_front();
            check_val($sformatf("%s c%0d buzz", name, k + 1), bus.buzz, e[2]);
            check_val($sformatf("%s c%0d busy", name, k + 1), bus.busy, e[1]);
            check_val($sformatf("%s c%0d drop", name, k + 1), bus.drop, e[0]);
        end
        bus.pulse = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        bus.pulse = 1'b0;

        // Single pulse: one beep, gap, back to idle at cycle 13.
        clear_scn();
        pat[0] = 1'b1;
        starts = '{1};
        fall   = 13;
        run_scn("single", 20);

        // Two queued requests: beeps at 1, 13, 25.
        clear_scn();
        pat[0] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b1;
        starts = '{1, 13, 25};
        fall   = 37;
        run_scn("queue2", 45);

        // Saturation: requests at 5 and 6 are dropped.
        clear_scn();
        pat[0] = 1'b1;
        for (int i = 2; i <= 6; i++) pat[i] = 1'b1;
        starts = '{1, 13, 25, 37};
        drops  = '{6, 7};
        fall   = 49;
        run_scn("satur", 56);

        // Reset mid-beep with one request queued: nothing resumes.
        clear_scn();
        pat[0] = 1'b1; pat[2] = 1'b1;
        rst_cyc = 5;
        starts  = '{1};
        fall    = 100;
        run_scn("midrst", 46);

        // Request in the last gap cycle chains directly.
        clear_scn();
        pat[0] = 1'b1; pat[12] = 1'b1;
        starts = '{1, 13};
        fall   = 25;
        run_scn("lastgap", 32);

        // Pulse held for four cycles: four separate beeps, no drop.
        clear_scn();
        for (int i = 0; i <= 3; i++) pat[i] = 1'b1;
        starts = '{1, 13, 25, 37};
        fall   = 49;
        run_scn("held", 56);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_buzzer_driver
`default_nettype wire
